// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Holds the scan FSM state encoding and the hex-to-segment code table.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        GUARD = 2'd2
    } state_t;

    // Bit order is {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_CODES [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to active-high seven-segment pattern.
// Purely combinational, no handshake.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] din,
    output logic [6:0] seg
);

    assign seg = SEG_CODES[din];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with a per-digit value store; SEG_SCAN_DP_EN adds per-digit dp bits.
// Latency: outputs registered, a write shows on SEG_DATA one edge after it is stored.
// Backpressure: none, writes are always taken; out-of-range writes pulse wr_err for one cycle.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 5,
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scan_en,
    input  logic                  wr_valid,
    input  logic [2:0]            wr_addr,
    input  logic [3:0]            wr_data,
    output logic                  wr_err,
    output logic [NUM_DIGITS-1:0] SEG_SEL,
    output logic [7:0]            SEG_DATA
);

    localparam int MAXC = (SCAN_DIV > GUARD_CYCLES) ? SCAN_DIV : GUARD_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    state_t                     state_q, state_d;
    logic [IW-1:0]              idx_q, idx_d, idx_nxt;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0][3:0] val_q, val_d;
    logic                       wr_err_q, wr_err_d;
    logic [NUM_DIGITS-1:0]      sel_q, sel_d;
    logic [7:0]                 data_q, data_d;
    logic [3:0]                 cur_val;
    logic                       cur_dp;
    logic [6:0]                 cur_seg;

`ifdef SEG_SCAN_DP_EN
    logic [NUM_DIGITS-1:0]      dp_q, dp_d;
`endif

    assign idx_nxt = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (!scan_en) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SHOW;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        cnt_d = '0;
                        if (GUARD_CYCLES == 0) begin
                            idx_d = idx_nxt;
                        end else begin
                            state_d = GUARD;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                GUARD: begin
                    if (cnt_q == GUARD_LAST) begin
                        state_d = SHOW;
                        cnt_d   = '0;
                        idx_d   = idx_nxt;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        val_d    = val_q;
        wr_err_d = 1'b0;
`ifdef SEG_SCAN_DP_EN
        dp_d     = dp_q;
`endif
        if (wr_valid) begin
            wr_err_d = (int'(wr_addr) >= NUM_DIGITS);
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (wr_addr == 3'(i)) begin
`ifdef SEG_SCAN_DP_EN
                    val_d[i] = {1'b0, wr_data[2:0]};
                    dp_d[i]  = wr_data[3];
`else
                    val_d[i] = wr_data;
`endif
                end
            end
        end
    end

    // Select from the next index so the registered data lines up with the registered select.
    always_comb begin
        cur_val = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IW'(i)) begin
                cur_val = val_q[i];
            end
        end
    end

`ifdef SEG_SCAN_DP_EN
    always_comb begin
        cur_dp = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IW'(i)) begin
                cur_dp = dp_q[i];
            end
        end
    end
`else
    assign cur_dp = 1'b0;
`endif

    seg7_decode u_dec (
        .din (cur_val),
        .seg (cur_seg)
    );

    always_comb begin
        sel_d  = '0;
        data_d = '0;
        if (state_d == SHOW) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                sel_d[i] = (idx_d == IW'(i));
            end
            data_d = {cur_dp, cur_seg};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            val_q    <= '0;
            wr_err_q <= 1'b0;
            sel_q    <= '0;
            data_q   <= '0;
`ifdef SEG_SCAN_DP_EN
            dp_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            val_q    <= val_d;
            wr_err_q <= wr_err_d;
            sel_q    <= sel_d;
            data_q   <= data_d;
`ifdef SEG_SCAN_DP_EN
            dp_q     <= dp_d;
`endif
        end
    end

    assign wr_err   = wr_err_q;
    assign SEG_SEL  = sel_q;
    assign SEG_DATA = data_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with NUM_DIGITS=5, SCAN_DIV=4, GUARD_CYCLES=2; SEG_SCAN_DP_EN adds the dp case.
module tb_seg_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       scan_en;
    logic       wr_valid;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_err;
    logic [4:0] SEG_SEL;
    logic [7:0] SEG_DATA;

    seg_scan_ctrl #(
        .NUM_DIGITS   (5),
        .SCAN_DIV     (4),
        .GUARD_CYCLES (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scan_en  (scan_en),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_err   (wr_err),
        .SEG_SEL  (SEG_SEL),
        .SEG_DATA (SEG_DATA)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [4:0] sel;
        logic [7:0] data;
        logic       err;
    } exp_t;

    typedef struct {
        logic       wv;
        logic [2:0] a;
        logic [3:0] d;
        logic       err;
    } vec_t;

    exp_t       sb[$];
    vec_t       tbl[6];
    int         checks   = 0;
    int         failures = 0;
    int         t        = 0;
    bit         running  = 0;
    logic [3:0] mdl [5];
    logic       mdp [5];

    function automatic logic [6:0] dec7(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;  4'h1: return 7'h06;
            4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;
            4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;
            4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;
            4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic clear_model();
        running = 0;
        for (int i = 0; i < 5; i++) begin
            mdl[i] = 4'h0;
            mdp[i] = 1'b0;
        end
    endtask

    // Drive one cycle of stimulus, predict the outputs after the next rising edge, compare.
    task automatic step(input logic en, input logic wv, input logic [2:0] a,
                        input logic [3:0] d, input logic exp_err);
        exp_t e;
        int   p;
        scan_en  = en;
        wr_valid = wv;
        wr_addr  = a;
        wr_data  = d;
        e = '0;
        if (rst_n) begin
            if (en) begin
                t = running ? t + 1 : 0;
                running = 1;
                p = t % 30;
                if ((p % 6) < 4) begin
                    e.sel  = 5'(1 << (p / 6));
                    e.data = {mdp[p / 6], dec7(mdl[p / 6])};
                end
            end else begin
                running = 0;
            end
            e.err = exp_err;
            if (wv && a < 5) begin
`ifdef SEG_SCAN_DP_EN
                mdl[a] = {1'b0, d[2:0]};
                mdp[a] = d[3];
`else
                mdl[a] = d;
`endif
            end
        end else begin
            clear_model();
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("seg_sel", 32'(SEG_SEL), 32'(e.sel));
        chk("seg_data", 32'(SEG_DATA), 32'(e.data));
        chk("wr_err", 32'(wr_err), 32'(e.err));
        chk("sel_onehot0", 32'($onehot0(SEG_SEL)), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_sel(input logic [4:0] target, input logic [7:0] exp_data, input string name);
        for (int i = 0; i < 40 && SEG_SEL != target; i++) begin
            step(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
        end
        if (SEG_SEL != target) begin
            chk({name, "_timeout"}, 32'(SEG_SEL), 32'(target));
        end else begin
            chk(name, 32'(SEG_DATA), 32'(exp_data));
        end
    endtask

    initial begin
        tbl[0] = '{1'b1, 3'd0, 4'h3, 1'b0};
        tbl[1] = '{1'b1, 3'd4, 4'h7, 1'b0};
        tbl[2] = '{1'b1, 3'd5, 4'h9, 1'b1};
        tbl[3] = '{1'b0, 3'd5, 4'h9, 1'b0};
        tbl[4] = '{1'b1, 3'd7, 4'hF, 1'b1};
        tbl[5] = '{1'b0, 3'd2, 4'h8, 1'b0};

        rst_n    = 1'b0;
        scan_en  = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = 3'd0;
        wr_data  = 4'd0;
        clear_model();
        @(negedge clk);
        @(negedge clk);
        chk("rst_sel", 32'(SEG_SEL), 32'd0);
        chk("rst_data", 32'(SEG_DATA), 32'd0);
        chk("rst_err", 32'(wr_err), 32'd0);
        rst_n = 1'b1;

        // Writes with the scan off, including out-of-range addresses.
        foreach (tbl[i]) begin
            step(1'b0, tbl[i].wv, tbl[i].a, tbl[i].d, tbl[i].err);
        end

        // Two full scan periods.
        for (int i = 0; i < 62; i++) begin
            step(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
        end
        wait_sel(5'b00001, 8'h4F, "digit0_val3");
        wait_sel(5'b10000, 8'h07, "digit4_val7");
        wait_sel(5'b00100, 8'h3F, "digit2_blank");

        // Rewrite digit 0 while it is on the display.
        for (int i = 0; i < 60 && !(running && (t % 30) == 1); i++) begin
            step(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
        end
        step(1'b1, 1'b1, 3'd0, 4'h5, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
        end

        // Drop the scan enable in the middle of digit 2, then restart.
        for (int i = 0; i < 60 && !(running && (t % 30) == 13); i++) begin
            step(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
        end

`ifdef SEG_SCAN_DP_EN
        step(1'b1, 1'b1, 3'd1, 4'b1101, 1'b0);
        wait_sel(5'b00010, 8'hED, "digit1_dp");
`endif

        // Asynchronous reset while a guard interval is active.
        for (int i = 0; i < 60 && !(running && (t % 6) == 4); i++) begin
            step(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sel", 32'(SEG_SEL), 32'd0);
        chk("arst_data", 32'(SEG_DATA), 32'd0);
        chk("arst_err", 32'(wr_err), 32'd0);
        clear_model();
        step(1'b1, 1'b1, 3'd0, 4'h8, 1'b0);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
        chk("post_rst_sel", 32'(SEG_SEL), 32'h1);
        chk("post_rst_data", 32'(SEG_DATA), 32'h3F);
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The module SHALL have parameter NUM_DIGITS, default 5, giving the number of multiplexed digits (legal 1..8).
REQ-002 The module SHALL have parameter SCAN_DIV, default 50000, giving the clock cycles each digit is driven (legal >= 2).
REQ-003 The module SHALL have parameter GUARD_CYCLES, default 2, giving the all-off cycles between digits (legal 0..255).
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port scan_en, input, 1 bit: 1 runs the scan; 0 blanks the display.
REQ-007 Port wr_valid, input, 1 bit: a digit write is requested this cycle.
REQ-008 Port wr_addr, input, 3 bits: the digit index to write.
REQ-009 Port wr_data, input, 4 bits: the hex value 0..F for that digit.
REQ-010 Port wr_err, output, 1 bit: one-cycle pulse when a write is dropped because its address is out of range.
REQ-011 Port SEG_SEL, output, NUM_DIGITS bits: one-hot, active-high digit enable; bit i drives digit i.
REQ-012 Port SEG_DATA, output, 8 bits: active-high segments; bits 0..6 = a..g, bit 7 = dp.

Function
REQ-013 The block SHALL hold one 4-bit value register per digit.
REQ-014 A write with wr_valid=1 and wr_addr<NUM_DIGITS SHALL update register wr_addr on that clock edge; writes are always accepted, with no back-pressure.
REQ-015 A write with wr_addr>=NUM_DIGITS SHALL change no register and SHALL raise wr_err for exactly the next cycle.
REQ-016 FSM states: IDLE (SEG_SEL=0, SEG_DATA=0), SHOW (SEG_SEL=one-hot(idx), SEG_DATA=decode(value[idx])) and GUARD (SEG_SEL=0, SEG_DATA=0).
REQ-017 In IDLE with scan_en=1, the next state SHALL be SHOW, with idx=0 and the cycle counter at 0.
REQ-018 SHOW SHALL last exactly SCAN_DIV cycles, then go to GUARD, or go directly to SHOW of the next digit if GUARD_CYCLES=0.
REQ-019 GUARD SHALL last exactly GUARD_CYCLES cycles, then go to SHOW with idx advanced.
REQ-020 idx SHALL wrap from NUM_DIGITS-1 to 0.
REQ-021 In any state, scan_en=0 SHALL send the FSM to IDLE on the next edge and clear idx and the counter; the outputs SHALL be 0 from that edge on.
REQ-022 SEG_SEL and SEG_DATA SHALL be registered. A write accepted at edge k to the digit currently shown SHALL appear on SEG_DATA after edge k+1, with no glitch on SEG_SEL.
REQ-023 The decode SHALL use these codes: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, B=7C, C=39, D=5E, E=79, F=71 (hex, bit 7 = 0).
REQ-024 SEG_SEL SHALL never have more than one bit set in any cycle.

Reset
REQ-025 On rst_n=0, the following SHALL be forced immediately, independent of clk: state=IDLE, idx=0, counter=0, all value registers=0, SEG_SEL=0, SEG_DATA=0, wr_err=0.
REQ-026 On rst_n=0 mid-scan, any write in the same cycle SHALL be lost; operation SHALL resume per REQ-017 on the first edge after release with scan_en=1.

Configuration
REQ-027 With the macro SEG_SCAN_DP_EN defined, the block SHALL hold a per-digit dp register written from wr_data[3] when wr_valid=1 and the write is in range under the new mapping. It SHALL be written alongside a 3-bit value from wr_data[2:0], giving a digit range of 0..7. SEG_DATA[7] SHALL equal dp[idx] during SHOW. The dp registers SHALL reset to 0.
REQ-028 Without SEG_SCAN_DP_EN, wr_data SHALL be a full 4-bit hex value and SEG_DATA[7] SHALL be constant 0.

Structure
REQ-029 A shared package seg_pkg SHALL hold the FSM state typedef (IDLE/SHOW/GUARD) and the 16-entry segment code constant table.
REQ-030 The decode SHALL be one combinational sub-module, seg7_decode (4-bit in, 7-bit out), instantiated once on value[idx].
REQ-031 The counter width SHALL be $clog2(max(SCAN_DIV, GUARD_CYCLES)+1).

Verification (bench parameters: SCAN_DIV=4, GUARD_CYCLES=2, NUM_DIGITS=5)
REQ-032 Reset release, then scan_en=1 -> SEG_SEL=00001 for 4 cycles, 00000 for 2 cycles, 00010 for 4 cycles, and so on; after digit 4 the pattern returns to 00001; period 30 cycles.
REQ-033 Writes of 3 to addr 0 and 7 to addr 4 -> SEG_DATA=4F while SEG_SEL=00001 and 07 while SEG_SEL=10000; other digits show 3F.
REQ-034 wr_addr=5, wr_data=9 -> wr_err high for exactly 1 cycle and no digit register changes.
REQ-035 scan_en dropped mid-SHOW of digit 2 -> outputs 0 from the next edge; re-enabling restarts at digit 0 with a full 4-cycle SHOW.
REQ-036 rst_n asserted mid-GUARD -> outputs 0 and registers 0 asynchronously; after release, digit 0 shows 3F.
REQ-037 With SEG_SCAN_DP_EN defined, a write with wr_data=1101 (binary) to addr 1 -> SEG_DATA=ED while digit 1 is shown.
